// File: rtl/smf_pkg.sv
// Shared sizing helpers and tap-address arithmetic for the per-channel sample rings.
package smf_pkg;

  localparam int MAX_AW = 16;

  function automatic int depth_of(input int aw);
    return 1 << aw;
  endfunction

  function automatic int nch_of(input int cw);
    return 1 << cw;
  endfunction

  // fill must reach DEPTH itself, so it needs one more bit than the pointer
  function automatic int fill_w(input int aw);
    return aw + 1;
  endfunction

  function automatic logic [MAX_AW-1:0] tap_addr(input logic [MAX_AW-1:0] ptr,
                                                 input logic [MAX_AW-1:0] tap,
                                                 input int aw);
    logic [MAX_AW-1:0] mask;
    mask = (MAX_AW'(1) << aw) - MAX_AW'(1);
    return (ptr - MAX_AW'(1) - tap) & mask;
  endfunction

endpackage

// File: rtl/sample_ram.sv
// Simple dual-port RAM: synchronous write, registered read-before-write read port.
module sample_ram #(
  parameter int AW = 9,
  parameter int DW = 18
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] wa,
  input  logic [DW-1:0] wd,
  input  logic          re,
  input  logic [AW-1:0] ra,
  output logic [DW-1:0] rd
);

  logic [DW-1:0] mem [2**AW];

  // read port only loads on a request so the output holds between reads
  always_ff @(posedge clk) begin
    if (we) mem[wa] <= wd;
    if (re) rd <= mem[ra];
  end

endmodule

// File: rtl/sample_ring_bank.sv
// Multi-channel circular sample store: per-channel write pointer and fill count,
// relative tap reads with zero masking for slots not yet written.
module sample_ring_bank
  import smf_pkg::*;
#(
  parameter int addrWidth = 8,
  parameter int dataWidth = 18,
  parameter int chanWidth = 1,
  parameter int outRegs   = 1
) (
  input  logic                          Clk_i,
  input  logic                          Rstn_i,
  input  logic                          Clr_i,
  input  logic                          DinVld_i,
  input  logic [chanWidth-1:0]          DinChan_i,
  input  logic [dataWidth-1:0]          Din_i,
  input  logic                          Rd_i,
  input  logic [chanWidth-1:0]          RdChan_i,
  input  logic [addrWidth-1:0]          RdTap_i,
  output logic [dataWidth-1:0]          Dout_o,
  output logic                          DoutVld_o,
  output logic [nch_of(chanWidth)-1:0]  Primed_o
);

  localparam int DEPTH = depth_of(addrWidth);
  localparam int NCH   = nch_of(chanWidth);
  localparam int FW    = fill_w(addrWidth);
  localparam int RAW   = addrWidth + chanWidth;
  localparam logic [FW-1:0] FULL = FW'(DEPTH);

  logic [addrWidth-1:0] wr_ptr [NCH];
  logic [FW-1:0]        fill   [NCH];
  logic [addrWidth-1:0] wr_slot;
  logic [addrWidth-1:0] rd_slot;
  logic                 tap_valid;
  logic [dataWidth-1:0] ram_q;
  logic [dataWidth-1:0] stage1;
  logic                 vld1;
  logic                 zero1;

  // a push in the clear cycle restarts its channel at slot 0
  assign wr_slot   = Clr_i ? '0 : wr_ptr[DinChan_i];
  assign rd_slot   = addrWidth'(tap_addr(MAX_AW'(wr_ptr[RdChan_i]), MAX_AW'(RdTap_i), addrWidth));
  assign tap_valid = FW'(RdTap_i) < fill[RdChan_i];

  sample_ram #(
    .AW (RAW),
    .DW (dataWidth)
  ) u_ram (
    .clk (Clk_i),
    .we  (DinVld_i),
    .wa  ({DinChan_i, wr_slot}),
    .wd  (Din_i),
    .re  (Rd_i),
    .ra  ({RdChan_i, rd_slot}),
    .rd  (ram_q)
  );

  always_ff @(posedge Clk_i or negedge Rstn_i) begin
    if (!Rstn_i) begin
      for (int c = 0; c < NCH; c++) begin
        wr_ptr[c] <= '0;
        fill[c]   <= '0;
      end
    end else begin
      if (Clr_i) begin
        for (int c = 0; c < NCH; c++) begin
          wr_ptr[c] <= '0;
          fill[c]   <= '0;
        end
      end
      if (DinVld_i) begin
        if (Clr_i) begin
          wr_ptr[DinChan_i] <= addrWidth'(1);
          fill[DinChan_i]   <= FW'(1);
        end else begin
          wr_ptr[DinChan_i] <= wr_ptr[DinChan_i] + addrWidth'(1);
          if (fill[DinChan_i] != FULL) fill[DinChan_i] <= fill[DinChan_i] + FW'(1);
        end
      end
    end
  end

  // zero1 resets high so Dout_o reads 0 out of reset without resetting the RAM
  always_ff @(posedge Clk_i or negedge Rstn_i) begin
    if (!Rstn_i) begin
      vld1  <= 1'b0;
      zero1 <= 1'b1;
    end else begin
      vld1 <= Rd_i;
      if (Rd_i) zero1 <= ~tap_valid;
    end
  end

  assign stage1 = zero1 ? '0 : ram_q;

  always_comb begin
    Primed_o = '0;
    for (int c = 0; c < NCH; c++) Primed_o[c] = (fill[c] == FULL);
  end

  if (outRegs == 2) begin : g_out2
    logic                 vld2;
    logic [dataWidth-1:0] dout_q;

    always_ff @(posedge Clk_i or negedge Rstn_i) begin
      if (!Rstn_i) begin
        vld2   <= 1'b0;
        dout_q <= '0;
      end else begin
        vld2 <= vld1;
        if (vld1) dout_q <= stage1;
      end
    end

    assign Dout_o    = dout_q;
    assign DoutVld_o = vld2;
  end else begin : g_out1
    assign Dout_o    = stage1;
    assign DoutVld_o = vld1;
  end

endmodule

// File: tb/tb_sample_ring_bank.sv
// Self-checking bench: two ring banks (1- and 2-cycle read latency) share stimulus
// and are compared against a queue-per-channel history model.
module tb_sample_ring_bank;

  localparam int AW = 3;
  localparam int DW = 18;
  localparam int CW = 1;
  localparam int DEPTH = 8;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          clr, din_vld, rd;
  logic [CW-1:0] din_chan, rd_chan;
  logic [DW-1:0] din;
  logic [AW-1:0] rd_tap;
  logic [DW-1:0] dout1, dout2;
  logic          vld1, vld2;
  logic [1:0]    primed1, primed2;

  sample_ring_bank #(.addrWidth(AW), .dataWidth(DW), .chanWidth(CW), .outRegs(1)) u_dut1 (
    .Clk_i(clk), .Rstn_i(rst_n), .Clr_i(clr), .DinVld_i(din_vld), .DinChan_i(din_chan),
    .Din_i(din), .Rd_i(rd), .RdChan_i(rd_chan), .RdTap_i(rd_tap),
    .Dout_o(dout1), .DoutVld_o(vld1), .Primed_o(primed1));

  sample_ring_bank #(.addrWidth(AW), .dataWidth(DW), .chanWidth(CW), .outRegs(2)) u_dut2 (
    .Clk_i(clk), .Rstn_i(rst_n), .Clr_i(clr), .DinVld_i(din_vld), .DinChan_i(din_chan),
    .Din_i(din), .Rd_i(rd), .RdChan_i(rd_chan), .RdTap_i(rd_tap),
    .Dout_o(dout2), .DoutVld_o(vld2), .Primed_o(primed2));

  always #5 clk = ~clk;

  typedef struct { int due; int data; } exp_t;
  typedef struct { int cyc; int data; } got_t;

  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;
  int   hist [2][$];
  exp_t expq[$];
  got_t got1[$];
  got_t got2[$];

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (vld1 === 1'b1) got1.push_back('{cyc, int'(dout1)});
    if (vld2 === 1'b1) got2.push_back('{cyc, int'(dout2)});
  end

  function automatic logic [1:0] model_primed();
    logic [1:0] p;
    p[0] = hist[0].size() >= DEPTH;
    p[1] = hist[1].size() >= DEPTH;
    return p;
  endfunction

  // one clock of stimulus; the model resolves the read against pre-push, pre-clear state
  task automatic step(input bit pv, input int pc, input int d, input bit rv, input int rc,
                      input int rt, input bit cl);
    int   n;
    int   f;
    exp_t e;
    din_vld = pv; din_chan = pc[0]; din = d[DW-1:0];
    rd = rv; rd_chan = rc[0]; rd_tap = rt[AW-1:0]; clr = cl;
    if (rv) begin
      n = hist[rc].size();
      f = (n < DEPTH) ? n : DEPTH;
      e.due  = cyc + 1;
      e.data = (rt < f) ? hist[rc][n-1-rt] : 0;
      expq.push_back(e);
    end
    if (cl) begin
      hist[0].delete();
      hist[1].delete();
    end
    if (pv) hist[pc].push_back(d & 32'h3FFFF);
    @(posedge clk); #1;
    din_vld = 1'b0; rd = 1'b0; clr = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    step(0, 0, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0, 0);
    checks++;
    if (dout1 !== '0 || dout2 !== '0 || vld1 !== 1'b0 || vld2 !== 1'b0) begin
      errors++;
      $display("FAIL reset_outputs dout1=%0h dout2=%0h vld1=%b vld2=%b required 0", dout1, dout2, vld1, vld2);
    end
    checks++;
    if (primed1 !== 2'b00 || primed2 !== 2'b00) begin
      errors++;
      $display("FAIL reset_primed got %b/%b required 00", primed1, primed2);
    end
    rst_n = 1'b1;
    step(0, 0, 0, 0, 0, 0, 0);
    step(0, 0, 0, 1, 0, 0, 0);
    repeat (4) step(0, 0, 0, 0, 0, 0, 0);
    checks++;
    if (got1.size() != expq.size() || got2.size() != expq.size()) begin
      errors++;
      $display("FAIL reset_read_count got %0d/%0d required %0d", got1.size(), got2.size(), expq.size());
    end else begin
      foreach (expq[i]) begin
        checks++;
        if (got1[i].cyc != expq[i].due || got1[i].data != expq[i].data ||
            got2[i].cyc != expq[i].due + 1 || got2[i].data != expq[i].data) begin
          errors++;
          $display("FAIL reset_read[%0d] got %0h@%0d/%0h@%0d required %0h@%0d", i,
                   got1[i].data, got1[i].cyc, got2[i].data, got2[i].cyc, expq[i].data, expq[i].due);
        end
      end
    end
    expq.delete(); got1.delete(); got2.delete();
  endtask

  task automatic test_basic();
    for (int v = 1; v <= 3; v++) step(1, 0, v, 0, 0, 0, 0);
    for (int t = 0; t < 4; t++) step(0, 0, 0, 1, 0, t, 0);
    step(0, 0, 0, 1, 0, 1, 0);
    repeat (4) step(0, 0, 0, 0, 0, 0, 0);
    checks++;
    if (got1.size() != expq.size() || got2.size() != expq.size()) begin
      errors++;
      $display("FAIL basic_count got %0d/%0d required %0d", got1.size(), got2.size(), expq.size());
    end else begin
      foreach (expq[i]) begin
        checks++;
        if (got1[i].cyc != expq[i].due || got1[i].data != expq[i].data ||
            got2[i].cyc != expq[i].due + 1 || got2[i].data != expq[i].data) begin
          errors++;
          $display("FAIL basic_read[%0d] got %0h@%0d/%0h@%0d required %0h@%0d", i,
                   got1[i].data, got1[i].cyc, got2[i].data, got2[i].cyc, expq[i].data, expq[i].due);
        end
      end
    end
    checks++;
    if (dout1 !== 18'd2 || dout2 !== 18'd2) begin
      errors++;
      $display("FAIL basic_hold got %0h/%0h required 2", dout1, dout2);
    end
    expq.delete(); got1.delete(); got2.delete();
  endtask

  task automatic test_wrap();
    for (int v = 1; v <= 10; v++) begin
      step(1, 1, v, 0, 0, 0, 0);
      if (v == 7 || v == 8) begin
        checks++;
        if (primed1 !== model_primed() || primed2 !== model_primed()) begin
          errors++;
          $display("FAIL wrap_primed push%0d got %b/%b required %b", v, primed1, primed2, model_primed());
        end
      end
    end
    for (int t = 0; t < DEPTH; t++) step(0, 0, 0, 1, 1, t, 0);
    repeat (4) step(0, 0, 0, 0, 0, 0, 0);
    checks++;
    if (got1.size() != expq.size() || got2.size() != expq.size()) begin
      errors++;
      $display("FAIL wrap_count got %0d/%0d required %0d", got1.size(), got2.size(), expq.size());
    end else begin
      foreach (expq[i]) begin
        checks++;
        if (got1[i].cyc != expq[i].due || got1[i].data != expq[i].data ||
            got2[i].cyc != expq[i].due + 1 || got2[i].data != expq[i].data) begin
          errors++;
          $display("FAIL wrap_read[%0d] got %0h@%0d/%0h@%0d required %0h@%0d", i,
                   got1[i].data, got1[i].cyc, got2[i].data, got2[i].cyc, expq[i].data, expq[i].due);
        end
      end
    end
    expq.delete(); got1.delete(); got2.delete();
  endtask

  task automatic test_same_cycle();
    for (int v = 11; v <= 18; v++) step(1, 0, v, 0, 0, 0, 0);
    step(1, 0, 99, 1, 0, DEPTH - 1, 0);
    step(0, 0, 0, 1, 0, 0, 0);
    step(0, 0, 0, 1, 0, DEPTH - 1, 0);
    repeat (4) step(0, 0, 0, 0, 0, 0, 0);
    checks++;
    if (got1.size() != expq.size() || got2.size() != expq.size()) begin
      errors++;
      $display("FAIL same_cycle_count got %0d/%0d required %0d", got1.size(), got2.size(), expq.size());
    end else begin
      foreach (expq[i]) begin
        checks++;
        if (got1[i].cyc != expq[i].due || got1[i].data != expq[i].data ||
            got2[i].cyc != expq[i].due + 1 || got2[i].data != expq[i].data) begin
          errors++;
          $display("FAIL same_cycle_read[%0d] got %0h@%0d/%0h@%0d required %0h@%0d", i,
                   got1[i].data, got1[i].cyc, got2[i].data, got2[i].cyc, expq[i].data, expq[i].due);
        end
      end
    end
    expq.delete(); got1.delete(); got2.delete();
  endtask

  task automatic test_channels_clear();
    step(0, 0, 0, 0, 0, 0, 1);
    for (int i = 0; i < 5; i++) begin
      step(1, 0, 100 + i, 0, 0, 0, 0);
      step(1, 1, 200 + i, 1, 0, i, 0);
    end
    for (int t = 0; t < DEPTH; t++) begin
      step(0, 0, 0, 1, 0, t, 0);
      step(0, 0, 0, 1, 1, t, 0);
    end
    step(1, 0, 5, 1, 1, 0, 1);
    checks++;
    if (primed1 !== 2'b00 || primed2 !== 2'b00) begin
      errors++;
      $display("FAIL clear_primed got %b/%b required 00", primed1, primed2);
    end
    step(0, 0, 0, 1, 0, 0, 0);
    step(0, 0, 0, 1, 0, 1, 0);
    for (int t = 0; t < DEPTH; t++) step(0, 0, 0, 1, 1, t, 0);
    repeat (4) step(0, 0, 0, 0, 0, 0, 0);
    checks++;
    if (got1.size() != expq.size() || got2.size() != expq.size()) begin
      errors++;
      $display("FAIL chan_clear_count got %0d/%0d required %0d", got1.size(), got2.size(), expq.size());
    end else begin
      foreach (expq[i]) begin
        checks++;
        if (got1[i].cyc != expq[i].due || got1[i].data != expq[i].data ||
            got2[i].cyc != expq[i].due + 1 || got2[i].data != expq[i].data) begin
          errors++;
          $display("FAIL chan_clear_read[%0d] got %0h@%0d/%0h@%0d required %0h@%0d", i,
                   got1[i].data, got1[i].cyc, got2[i].data, got2[i].cyc, expq[i].data, expq[i].due);
        end
      end
    end
    expq.delete(); got1.delete(); got2.delete();
  endtask

  task automatic test_random();
    int mism;
    mism = 0;
    for (int k = 0; k < 400; k++) begin
      step(bit'($urandom_range(0, 1)), int'($urandom_range(0, 1)), int'($urandom_range(0, 262143)),
           bit'($urandom_range(0, 9) < 7), int'($urandom_range(0, 1)), int'($urandom_range(0, DEPTH - 1)),
           bit'($urandom_range(0, 39) == 0));
      if (primed1 !== model_primed() || primed2 !== model_primed()) mism++;
    end
    checks++;
    if (mism != 0) begin
      errors++;
      $display("FAIL random_primed mismatching cycles %0d required 0", mism);
    end
    repeat (4) step(0, 0, 0, 0, 0, 0, 0);
    checks++;
    if (got1.size() != expq.size() || got2.size() != expq.size()) begin
      errors++;
      $display("FAIL random_count got %0d/%0d required %0d", got1.size(), got2.size(), expq.size());
    end else begin
      foreach (expq[i]) begin
        checks++;
        if (got1[i].cyc != expq[i].due || got1[i].data != expq[i].data ||
            got2[i].cyc != expq[i].due + 1 || got2[i].data != expq[i].data) begin
          errors++;
          $display("FAIL random_read[%0d] got %0h@%0d/%0h@%0d required %0h@%0d", i,
                   got1[i].data, got1[i].cyc, got2[i].data, got2[i].cyc, expq[i].data, expq[i].due);
        end
      end
    end
    expq.delete(); got1.delete(); got2.delete();
  endtask

  task automatic test_reset_midread();
    step(1, 0, 77, 0, 0, 0, 0);
    step(0, 0, 0, 1, 0, 0, 0);
    // the read above is in flight; reset must swallow it
    rst_n = 1'b0;
    hist[0].delete(); hist[1].delete();
    expq.delete();
    repeat (2) step(0, 0, 0, 0, 0, 0, 0);
    rst_n = 1'b1;
    repeat (4) step(0, 0, 0, 0, 0, 0, 0);
    checks++;
    if (got1.size() != 0 || got2.size() != 0) begin
      errors++;
      $display("FAIL midreset_vld got %0d/%0d pulses required 0", got1.size(), got2.size());
    end
    checks++;
    if (dout1 !== '0 || dout2 !== '0 || primed1 !== 2'b00 || primed2 !== 2'b00) begin
      errors++;
      $display("FAIL midreset_outputs dout %0h/%0h primed %b/%b required 0", dout1, dout2, primed1, primed2);
    end
    got1.delete(); got2.delete();
  endtask

  initial begin
    rst_n = 1'b0; clr = 1'b0; din_vld = 1'b0; rd = 1'b0;
    din_chan = '0; rd_chan = '0; din = '0; rd_tap = '0;
    test_reset();
    test_basic();
    test_wrap();
    test_same_cycle();
    test_channels_clear();
    test_random();
    test_reset_midread();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/sample_ring_bank.md
# sample_ring_bank

Multi-channel circular sample store for the single-MAC FIR datapath: the input stage pushes one sample per cycle into a per-channel ring, and the MAC sequencer reads any tap by relative index (0 = newest). Taps not yet written since reset or clear read as zero, giving the filter a zero-initialised delay line without a memory flush. Read latency is 1 or 2 cycles by parameter.

## Interface
- addrWidth, 8, log2 of ring depth per channel (DEPTH = 2**addrWidth)
- dataWidth, 18, sample width
- chanWidth, 1, log2 of channel count (NCH = 2**chanWidth)
- outRegs, 1, read latency in cycles; legal values 1 or 2
- Clk_i  in  1  single clock; all logic on rising edge
- Rstn_i  in  1  reset, asynchronous, active-low
- Clr_i  in  1  synchronous flush of all channels' pointers and fill counts
- DinVld_i  in  1  push Din_i into channel DinChan_i
- DinChan_i  in  chanWidth  target channel of push
- Din_i  in  dataWidth  sample
- Rd_i  in  1  read request
- RdChan_i  in  chanWidth  channel to read
- RdTap_i  in  addrWidth  tap index, 0 = newest sample
- Dout_o  out  dataWidth  tap value
- DoutVld_o  out  1  Dout_o carries the result of a read issued outRegs cycles earlier
- Primed_o  out  NCH  bit c set when channel c holds DEPTH samples

## Operation
- Storage: one simple dual-port RAM of NCH*DEPTH words; write address {DinChan_i, wrPtr[DinChan_i]}, read address {RdChan_i, (wrPtr[RdChan_i] - 1 - RdTap_i) mod DEPTH}. RAM contents are never reset.
- Per-channel state: wrPtr (addrWidth bits, wraps DEPTH-1 -> 0) and fill (addrWidth+1 bits, saturates at DEPTH).
- Push: RAM write; wrPtr[c] += 1 mod DEPTH; fill[c] += 1 unless already DEPTH.
- Read: tap valid iff RdTap_i < fill[RdChan_i] (sampled at issue); invalid taps return 0 regardless of RAM contents.
- Read and push in same cycle, same channel: read resolves against pre-push pointer and fill; tap 0 = previous newest. Tap DEPTH-1 with full ring addresses the slot being overwritten -> returns old (oldest) sample (read-before-write RAM).
- Clr_i: all wrPtr and fill to 0 next cycle. Clr_i with DinVld_i: clear applied first, sample lands in slot 0 of DinChan_i, that channel's fill = 1, wrPtr = 1. Reads issued in the Clr_i cycle use pre-clear state.
- Primed_o[c] = (fill[c] == DEPTH), registered state, no extra latency.
- Reset: wrPtr, fill = 0; Primed_o = 0; Dout_o = 0; DoutVld_o = 0; pipeline valid bits = 0. Reset mid-read drops in-flight results (no DoutVld_o after release).

## Timing
- outRegs=1: Rd_i at edge n -> Dout_o/DoutVld_o valid after edge n+1 (RAM output register).
- outRegs=2: one extra output register; valid after edge n+2.
- Back-to-back reads every cycle sustained; no stall, no backpressure.
- Zero-mask flag travels alongside RAM output with identical latency.
- Dout_o holds last value when DoutVld_o = 0.
- Write visible to reads issued the cycle after the push (tap 0).

## Structure
- Package smf_pkg: DEPTH/NCH derivation, fill-count width, tap-address function (pointer minus 1 minus tap, modulo DEPTH).
- Sub-module sample_ram: simple dual-port RAM, sync write, registered read, read-before-write, block-RAM inferable; top adds pointers, fill counters, masking, optional second register.

## Test plan
- Reset then read ch0 tap 0 -> Dout_o = 0, DoutVld_o = 1 after outRegs cycles; Primed_o = 0.
- Push 1,2,3 into ch0; read taps 0,1,2,3 -> 3,2,1,0.
- addrWidth=3: push 1..10 into ch1 -> Primed_o[1]=1 after 8th push; read tap 0 -> 10, tap 7 -> 3 (wrap).
- Full ring, same-cycle push 99 and read tap 7 on ch0 -> returns oldest pre-push sample; next-cycle tap 0 -> 99.
- Interleave pushes to ch0 (100+) and ch1 (200+) -> reads never cross channels; Clr_i with push 5 to ch0 -> ch0 tap0 = 5, tap1 = 0, ch1 all taps 0.
- Rstn_i low during a read with outRegs=2 -> no DoutVld_o pulse, all outputs 0 until new read.
